// File: rtl/mem_access_unit.sv
// Memory-access stage engine: turns the MA-stage load/store into a req/ack bus
// transaction, stalls the pipeline while it is in flight and returns extended load data.
module mem_access_unit #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy_wait,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  // Loads and stores decode funct3 differently: 100/101 are unsigned loads but plain SW for stores.
  function automatic logic [1:0] width_of(input logic is_load, input logic [2:0] f3);
    logic [1:0] w;
    w = W_WORD;
    if (is_load) begin
      case (f3)
        3'b000, 3'b100: w = W_BYTE;
        3'b001, 3'b101: w = W_HALF;
        default:        w = W_WORD;
      endcase
    end else begin
      case (f3)
        3'b000:  w = W_BYTE;
        3'b001:  w = W_HALF;
        default: w = W_WORD;
      endcase
    end
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [2:0] f3,
                                               input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{off, 3'b000} +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_q, we_q, err_q, ld_q;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic [3:0]       be_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;

  logic        op, fault, start_d;
  logic [1:0]  wid;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  always_comb begin
    op      = mem_read | mem_write;
    wid     = width_of(mem_read, funct3);
    fault   = ((wid == W_HALF) & alu_out[0]) | ((wid == W_WORD) & (|alu_out[1:0]));
    start_d = (state_q == IDLE) & op & ~fault;
    be_d    = 4'b1111;
    wdata_d = 32'd0;
    if (!mem_read) begin
      case (wid)
        W_BYTE: begin
          be_d    = 4'b0001 << alu_out[1:0];
          wdata_d = {4{store_data[7:0]}};
        end
        W_HALF: begin
          be_d    = 4'b0011 << {alu_out[1], 1'b0};
          wdata_d = {2{store_data[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = store_data;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_d) begin
            req_q   <= 1'b1;
            we_q    <= ~mem_read;
            addr_q  <= {alu_out[31:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ld_q    <= mem_read;
            f3_q    <= funct3;
            off_q   <= alu_out[1:0];
            cnt_q   <= '0;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          // An ack landing on the final timeout cycle still completes normally.
          if (mem_ack) begin
            req_q   <= 1'b0;
            if (ld_q) rdata_q <= load_extract(mem_rdata, f3_q, off_q);
            state_q <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            req_q   <= 1'b0;
            if (ld_q) rdata_q <= 32'd0;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_be     = be_q;
  assign mem_wdata  = wdata_q;
  assign read_data  = rdata_q;
  assign bus_error  = err_q;
  assign misaligned = (state_q == IDLE) & op & fault;
  assign busy_wait  = start_d | (state_q == ACCESS);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, alignment faults, timeout and reset.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_out, store_data, mem_rdata;
  logic        mem_ack;
  logic        mem_req, mem_we, busy_wait, misaligned, bus_error;
  logic [31:0] mem_addr, mem_wdata, read_data;
  logic [3:0]  mem_be;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_access_unit #(.ACK_TIMEOUT(4), .CNT_W(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .alu_out(alu_out), .store_data(store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy_wait(busy_wait), .read_data(read_data), .misaligned(misaligned),
    .bus_error(bus_error)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; mem_read = 0; mem_write = 0; funct3 = 0;
    alu_out = 0; store_data = 0; mem_rdata = 0; mem_ack = 0;
    @(negedge CLK);
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %0h want 0", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got %0h want 0", mem_addr); end
    n_cmp++; if (mem_be !== 4'h0) begin n_fail++; $display("FAIL rst_be got %0h want 0", mem_be); end
    n_cmp++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %0h want 0", read_data); end
    n_cmp++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL rst_berr got %0h want 0", bus_error); end
    n_cmp++; if (busy_wait !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0h want 0", busy_wait); end
    step(); RESET_N = 1'b1;
  endtask

  task automatic test_lw();
    step(); mem_read = 1; funct3 = 3'b010; alu_out = 32'h100;
    @(negedge CLK);
    n_cmp++; if (busy_wait !== 1'b1) begin n_fail++; $display("FAIL lw_busy_idle got %0h want 1", busy_wait); end
    n_cmp++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL lw_misal got %0h want 0", misaligned); end
    step(); mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge CLK);
    n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL lw_req got %0h want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL lw_addr got %0h want 100", mem_addr); end
    n_cmp++; if (mem_be !== 4'hF) begin n_fail++; $display("FAIL lw_be got %0h want f", mem_be); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL lw_we got %0h want 0", mem_we); end
    n_cmp++; if (busy_wait !== 1'b1) begin n_fail++; $display("FAIL lw_busy_acc got %0h want 1", busy_wait); end
    step(); mem_ack = 0;
    @(negedge CLK);
    n_cmp++; if (busy_wait !== 1'b0) begin n_fail++; $display("FAIL lw_busy_done got %0h want 0", busy_wait); end
    n_cmp++; if (read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata got %0h want deadbeef", read_data); end
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL lw_req_done got %0h want 0", mem_req); end
    step(); mem_read = 0;
    @(negedge CLK);
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL lw_noreissue got %0h want 0", mem_req); end
  endtask

  task automatic test_lb_lbu();
    logic [2:0]  f3s [2];
    logic [31:0] exps [2];
    f3s[0] = 3'b000; exps[0] = 32'hFFFFFF80;
    f3s[1] = 3'b100; exps[1] = 32'h00000080;
    for (int i = 0; i < 2; i++) begin
      step(); mem_read = 1; funct3 = f3s[i]; alu_out = 32'h103;
      @(negedge CLK);
      n_cmp++; if (busy_wait !== 1'b1) begin n_fail++; $display("FAIL lb%0d_busy got %0h want 1", i, busy_wait); end
      step(); mem_ack = 1; mem_rdata = 32'h80123456;
      @(negedge CLK);
      n_cmp++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL lb%0d_addr got %0h want 100", i, mem_addr); end
      n_cmp++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL lb%0d_wdata got %0h want 0", i, mem_wdata); end
      step(); mem_ack = 0;
      @(negedge CLK);
      n_cmp++; if (read_data !== exps[i]) begin n_fail++; $display("FAIL lb%0d_rdata got %0h want %0h", i, read_data, exps[i]); end
      step(); mem_read = 0;
    end
  endtask

  task automatic test_sh();
    mem_write = 1; funct3 = 3'b001; alu_out = 32'h202; store_data = 32'h1234ABCD;
    @(negedge CLK);
    n_cmp++; if (busy_wait !== 1'b1) begin n_fail++; $display("FAIL sh_busy got %0h want 1", busy_wait); end
    for (int c = 1; c <= 3; c++) begin
      step(); mem_ack = (c == 3); mem_rdata = 32'h55555555;
      @(negedge CLK);
      n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL sh_req%0d got %0h want 1", c, mem_req); end
      n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL sh_we%0d got %0h want 1", c, mem_we); end
      n_cmp++; if (mem_be !== 4'b1100) begin n_fail++; $display("FAIL sh_be%0d got %0h want c", c, mem_be); end
      n_cmp++; if (mem_wdata !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_wdata%0d got %0h want abcdabcd", c, mem_wdata); end
      n_cmp++; if (mem_addr !== 32'h200) begin n_fail++; $display("FAIL sh_addr%0d got %0h want 200", c, mem_addr); end
    end
    step(); mem_ack = 0;
    @(negedge CLK);
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL sh_req_done got %0h want 0", mem_req); end
    n_cmp++; if (busy_wait !== 1'b0) begin n_fail++; $display("FAIL sh_busy_done got %0h want 0", busy_wait); end
    n_cmp++; if (read_data !== 32'h80) begin n_fail++; $display("FAIL sh_rdata got %0h want 80", read_data); end
    step(); mem_write = 0;
  endtask

  task automatic test_misaligned();
    mem_read = 1; funct3 = 3'b010; alu_out = 32'h101;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_cmp++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_flag%0d got %0h want 1", c, misaligned); end
      n_cmp++; if (busy_wait !== 1'b0) begin n_fail++; $display("FAIL mis_busy%0d got %0h want 0", c, busy_wait); end
      n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mis_req%0d got %0h want 0", c, mem_req); end
      step();
    end
    mem_read = 0; mem_write = 1; funct3 = 3'b001; alu_out = 32'h203;
    @(negedge CLK);
    n_cmp++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_sh got %0h want 1", misaligned); end
    step(); funct3 = 3'b010; alu_out = 32'h104; store_data = 32'hCAFEF00D;
    @(negedge CLK);
    n_cmp++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL sw_misal got %0h want 0", misaligned); end
    n_cmp++; if (busy_wait !== 1'b1) begin n_fail++; $display("FAIL sw_busy got %0h want 1", busy_wait); end
    step(); mem_ack = 1;
    @(negedge CLK);
    n_cmp++; if (mem_be !== 4'hF) begin n_fail++; $display("FAIL sw_be got %0h want f", mem_be); end
    n_cmp++; if (mem_wdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL sw_wdata got %0h want cafef00d", mem_wdata); end
    n_cmp++; if (mem_addr !== 32'h104) begin n_fail++; $display("FAIL sw_addr got %0h want 104", mem_addr); end
    step(); mem_ack = 0;
    @(negedge CLK);
    n_cmp++; if (read_data !== 32'h80) begin n_fail++; $display("FAIL sw_rdata got %0h want 80", read_data); end
    step(); mem_write = 0;
  endtask

  task automatic test_timeout();
    mem_read = 1; funct3 = 3'b010; alu_out = 32'h10;
    for (int c = 1; c <= 4; c++) begin
      step();
      @(negedge CLK);
      n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL to_req%0d got %0h want 1", c, mem_req); end
      n_cmp++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL to_berr%0d got %0h want 0", c, bus_error); end
    end
    step();
    @(negedge CLK);
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL to_req_done got %0h want 0", mem_req); end
    n_cmp++; if (bus_error !== 1'b1) begin n_fail++; $display("FAIL to_berr_pulse got %0h want 1", bus_error); end
    n_cmp++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL to_rdata got %0h want 0", read_data); end
    n_cmp++; if (busy_wait !== 1'b0) begin n_fail++; $display("FAIL to_busy got %0h want 0", busy_wait); end
    step(); mem_read = 0;
    @(negedge CLK);
    n_cmp++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL to_berr_clear got %0h want 0", bus_error); end
    step(); mem_read = 1;
    for (int c = 1; c <= 4; c++) begin
      step(); mem_ack = (c == 4); mem_rdata = 32'h11223344;
      @(negedge CLK);
      n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL race_req%0d got %0h want 1", c, mem_req); end
    end
    step(); mem_ack = 0;
    @(negedge CLK);
    n_cmp++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL race_berr got %0h want 0", bus_error); end
    n_cmp++; if (read_data !== 32'h11223344) begin n_fail++; $display("FAIL race_rdata got %0h want 11223344", read_data); end
    step(); mem_read = 0;
  endtask

  task automatic test_reset_mid();
    mem_read = 1; funct3 = 3'b010; alu_out = 32'h40;
    step(); #1;
    n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rm_req_pre got %0h want 1", mem_req); end
    RESET_N = 1'b0; mem_read = 0;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rm_req got %0h want 0", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_addr got %0h want 0", mem_addr); end
    n_cmp++; if (mem_be !== 4'h0) begin n_fail++; $display("FAIL rm_be got %0h want 0", mem_be); end
    n_cmp++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL rm_rdata got %0h want 0", read_data); end
    n_cmp++; if (busy_wait !== 1'b0) begin n_fail++; $display("FAIL rm_busy got %0h want 0", busy_wait); end
    step(); mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    step(); RESET_N = 1'b1;
    @(negedge CLK);
    n_cmp++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL rm_stray_rdata got %0h want 0", read_data); end
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rm_stray_req got %0h want 0", mem_req); end
    step(); mem_ack = 0; mem_read = 1; alu_out = 32'h100;
    step(); mem_ack = 1; mem_rdata = 32'h0BADF00D;
    @(negedge CLK);
    n_cmp++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL rm_lw_addr got %0h want 100", mem_addr); end
    step(); mem_ack = 0;
    @(negedge CLK);
    n_cmp++; if (read_data !== 32'h0BADF00D) begin n_fail++; $display("FAIL rm_lw_rdata got %0h want badf00d", read_data); end
    step(); mem_read = 0;
  endtask

  task automatic test_back_to_back();
    mem_read = 1; mem_write = 1; funct3 = 3'b001; alu_out = 32'h102; store_data = 32'hFFFFFFFF;
    step(); mem_ack = 1; mem_rdata = 32'h80123456;
    @(negedge CLK);
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL b2b_lh_we got %0h want 0", mem_we); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL b2b_lh_wdata got %0h want 0", mem_wdata); end
    step(); mem_ack = 0;
    @(negedge CLK);
    n_cmp++; if (read_data !== 32'hFFFF8012) begin n_fail++; $display("FAIL b2b_lh_rdata got %0h want ffff8012", read_data); end
    step(); mem_read = 0; mem_write = 1; funct3 = 3'b000; alu_out = 32'h301; store_data = 32'h5A;
    @(negedge CLK);
    n_cmp++; if (busy_wait !== 1'b1) begin n_fail++; $display("FAIL b2b_sb_busy got %0h want 1", busy_wait); end
    step(); mem_ack = 1;
    @(negedge CLK);
    n_cmp++; if (mem_be !== 4'b0010) begin n_fail++; $display("FAIL b2b_sb_be got %0h want 2", mem_be); end
    n_cmp++; if (mem_wdata !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL b2b_sb_wdata got %0h want 5a5a5a5a", mem_wdata); end
    n_cmp++; if (mem_addr !== 32'h300) begin n_fail++; $display("FAIL b2b_sb_addr got %0h want 300", mem_addr); end
    step(); mem_ack = 0;
    @(negedge CLK);
    n_cmp++; if (read_data !== 32'hFFFF8012) begin n_fail++; $display("FAIL b2b_sb_rdata got %0h want ffff8012", read_data); end
    step(); mem_write = 0; mem_read = 1; funct3 = 3'b101; alu_out = 32'h102;
    step(); mem_ack = 1; mem_rdata = 32'h80123456;
    step(); mem_ack = 0;
    @(negedge CLK);
    n_cmp++; if (read_data !== 32'h00008012) begin n_fail++; $display("FAIL b2b_lhu_rdata got %0h want 8012", read_data); end
    step(); mem_read = 0;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-access (MA) stage engine. It sits between the EX/MA pipeline register and the MA/WB pipeline register.
- Takes the load/store request for the instruction in MA and drives a word-wide req/ack data-memory bus. It stalls the pipeline while the bus is busy.
- For loads, it delivers the byte/half/word result, already extended, on read_data for MA/WB to latch.
- Stores get byte-enables and lane-replicated write data.

Parameters:
- ACK_TIMEOUT, 16, max cycles mem_req is held in ACCESS without mem_ack before the access is aborted. Legal range 1..255.
- CNT_W, 8, width of the timeout counter. Must satisfy 2^CNT_W > ACK_TIMEOUT.

Ports:
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- mem_read  in  1  load in MA (from EX/MA)
- mem_write  in  1  store in MA (from EX/MA)
- funct3  in  3  RV32 load/store funct3
- alu_out  in  32  effective byte address
- store_data  in  32  rs2 value for stores
- mem_req  out  1  bus request, registered
- mem_we  out  1  1 = write, registered
- mem_addr  out  32  word address {alu_out[31:2],2'b00}, registered
- mem_be  out  4  byte enables, registered
- mem_wdata  out  32  lane-aligned write data, registered
- mem_rdata  in  32  read word, valid with mem_ack
- mem_ack  in  1  one-cycle completion from memory
- busy_wait  out  1  stall for PC, IF/ID, ID/EX, EX/MA and MA/WB
- read_data  out  32  extended load result to MA/WB, registered
- misaligned  out  1  combinational, alignment fault on current op
- bus_error  out  1  registered, one-cycle pulse on timeout

Behaviour:
- Reset (asynchronous, any state including mid-access):
  - State goes to IDLE and the counter clears.
  - mem_req, mem_we, mem_addr, mem_be, mem_wdata, read_data and bus_error go to 0 immediately.
  - A late mem_ack after reset is ignored.
- op = mem_read | mem_write. If both are set, the op is a load and the write is ignored.
- Alignment faults:
  - LH/LHU/SH with alu_out[0]=1.
  - LW/SW (and the default width) with alu_out[1:0]!=0.
  - misaligned = IDLE & op & fault.
  - On a fault: no bus request, busy_wait=0, read_data unchanged.
- Width decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011/110/111 are treated as LW.
  - Stores: 000 SB, 001 SH; all others are treated as SW.
- Store lanes:
  - SB: be = 4'b0001<<addr[1:0], wdata = byte replicated x4.
  - SH: be = 4'b0011<<{addr[1],1'b0}, wdata = half replicated x2.
  - SW: be = 4'b1111, wdata = store_data.
- Loads always use mem_be=4'b1111 and mem_wdata=0.
- Load extraction: the selected byte/half is taken from mem_rdata by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE:
    - On op & !fault: register the bus outputs, set mem_req=1 and go to ACCESS.
    - Otherwise stay in IDLE.
  - ACCESS:
    - mem_req and the other bus outputs are held stable.
    - The counter increments every cycle.
    - On mem_ack: for loads, register the extracted value into read_data. Drop mem_req and go to DONE.
    - If the counter reaches ACK_TIMEOUT with no ack: drop mem_req, set read_data=0 (loads only), pulse bus_error and go to DONE.
    - If mem_ack arrives in the same cycle as the timeout, the ack wins.
  - DONE:
    - Lasts exactly one cycle; the pipeline advances and MA/WB latches read_data.
    - Always returns to IDLE and never issues a new request, even though the same op is still present on the inputs.
- busy_wait = (IDLE & op & !fault) | ACCESS. It is 0 in DONE.
- Latency: with ack in the Nth ACCESS cycle, busy_wait is high for N+1 cycles and read_data is valid from DONE onward.
  - read_data holds until the next load completes; stores do not modify it.
- Back-to-back ops: the next op is seen in the IDLE cycle after DONE (no bubble beyond DONE).

Test Plan:
- LW, alu_out=0x100, ack in 1st ACCESS cycle with mem_rdata=0xDEADBEEF -> mem_addr=0x100, be=1111, busy_wait high 2 cycles, read_data=0xDEADBEEF in DONE.
- LB at 0x103 and LBU at 0x103, mem_rdata=0x80123456 -> read_data=0xFFFFFF80 and 0x00000080 respectively.
- SH, alu_out=0x202, store_data=0x1234ABCD, ack after 3 cycles -> mem_we=1, be=1100, wdata=0xABCDABCD, mem_addr=0x200, req held stable 3 cycles, read_data unchanged.
- LW at 0x101 -> misaligned=1, mem_req never asserted, busy_wait=0; SW at 0x104 right after -> normal access.
- Load with ACK_TIMEOUT=4 and mem_ack tied 0 -> mem_req high 4 cycles, bus_error pulses 1 cycle, read_data=0, returns to IDLE; then ack asserted on the timeout cycle in a rerun -> normal completion, no bus_error.
- RESET_N low mid-ACCESS, then a stray mem_ack -> all outputs 0 asynchronously, state IDLE, no read_data update; the next LW completes normally.
